// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath types used by the register file and its neighbours.
package legv8_pkg;

  typedef logic [63:0] word_t;
  typedef logic [4:0]  reg_addr_t;

  localparam reg_addr_t XZR = 5'd31;

endpackage

// File: rtl/reg_64_bits.sv
// One register-file entry: synchronous active-low clear, then load on enable.
module reg_64_bits #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear wins over a load in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/wb_read_port.sv
// Combinational read port: zero register, optional write-through, else stored entry.
module wb_read_port #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] entries [NUM_REGS-1],
  input  logic              byp_valid,
  input  logic [ADDR_W-1:0] byp_addr,
  input  logic [DATA_W-1:0] byp_data,
  output logic [DATA_W-1:0] data
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(NUM_REGS - 1);

  // Compare-based select keeps unmatched addresses at zero instead of X.
  always_comb begin
    data = '0;
    if (addr != ZERO_ADDR) begin
      if (byp_valid && (addr == byp_addr)) begin
        data = byp_data;
      end else begin
        for (int i = 0; i < NUM_REGS - 1; i++) begin
          if (addr == ADDR_W'(i)) begin
            data = entries[i];
          end
        end
      end
    end
  end

endmodule

// File: rtl/wb_reg_file.sv
// LEGv8 write-back register file, 31 stored entries plus hardwired XZR, two read ports.
// Define WB_REGFILE_BYPASS_EN to forward the write-back value to a same-cycle read.
module wb_reg_file
  import legv8_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(NUM_REGS - 1);

  logic [DATA_W-1:0]   entries [NUM_REGS-1];
  logic [NUM_REGS-2:0] wr_en;
  logic                wr_ok;
  logic                byp_valid;

  assign wr_ok = RegWrite && (wr_addr != ZERO_ADDR);

  // One-hot write decoder; XZR has no entry so its writes vanish here.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      wr_en[i] = wr_ok && (wr_addr == ADDR_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_REGS - 1; g++) begin : g_entry
    reg_64_bits #(
      .WIDTH (DATA_W)
    ) u_reg (
      .clk   (clk),
      .reset (reset),
      .en    (wr_en[g]),
      .d     (wr_data),
      .q     (entries[g])
    );
  end

`ifdef WB_REGFILE_BYPASS_EN
  // A write being discarded by reset must not be forwarded either.
  assign byp_valid = reset && wr_ok;
`else
  assign byp_valid = 1'b0;
`endif

  wb_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_port_a (
    .addr      (rd_addr_a),
    .entries   (entries),
    .byp_valid (byp_valid),
    .byp_addr  (wr_addr),
    .byp_data  (wr_data),
    .data      (rd_data_a)
  );

  wb_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_port_b (
    .addr      (rd_addr_b),
    .entries   (entries),
    .byp_valid (byp_valid),
    .byp_addr  (wr_addr),
    .byp_data  (wr_data),
    .data      (rd_data_b)
  );

endmodule

// File: tb/tb_wb_reg_file.sv
// Directed bench for wb_reg_file; expectations follow WB_REGFILE_BYPASS_EN when defined.
module tb_wb_reg_file;
  import legv8_pkg::*;

  logic      clk = 1'b0;
  logic      reset;
  word_t     wr_data;
  reg_addr_t wr_addr;
  logic      RegWrite;
  reg_addr_t rd_addr_a;
  reg_addr_t rd_addr_b;
  word_t     rd_data_a;
  word_t     rd_data_b;

  int check_count = 0;
  int error_count = 0;

  wb_reg_file dut (
    .clk       (clk),
    .reset     (reset),
    .wr_data   (wr_data),
    .wr_addr   (wr_addr),
    .RegWrite  (RegWrite),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input word_t observed, input word_t expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed 0x%016h expected 0x%016h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic we, input reg_addr_t wa,
                               input word_t wd, input reg_addr_t ra, input reg_addr_t rb);
    reset     = rst;
    RegWrite  = we;
    wr_addr   = wa;
    wr_data   = wd;
    rd_addr_a = ra;
    rd_addr_b = rb;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    word_t exp_a;

    // Two reset edges with a competing write to X3
    applyStimulus(1'b0, 1'b1, 5'd3, 64'hDEAD, 5'd3, 5'd3);
    tick();
    tick();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 1'b0, 5'd3, 64'hDEAD, reg_addr_t'(i), reg_addr_t'(31 - i));
      checkOutput($sformatf("reset_a_x%0d", i), rd_data_a, 64'h0);
      checkOutput($sformatf("reset_b_x%0d", 31 - i), rd_data_b, 64'h0);
    end

    // Basic write to X5
    applyStimulus(1'b1, 1'b1, 5'd5, 64'h0123_4567_89AB_CDEF, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 5'd0, 64'h0, 5'd5, 5'd5);
    checkOutput("x5_a", rd_data_a, 64'h0123_4567_89AB_CDEF);
    checkOutput("x5_b", rd_data_b, 64'h0123_4567_89AB_CDEF);

    // XZR write is dropped and never forwarded
    applyStimulus(1'b1, 1'b1, XZR, '1, XZR, XZR);
    checkOutput("xzr_same_a", rd_data_a, 64'h0);
    checkOutput("xzr_same_b", rd_data_b, 64'h0);
    tick();
    checkOutput("xzr_next_a", rd_data_a, 64'h0);
    checkOutput("xzr_next_b", rd_data_b, 64'h0);

    // Same-cycle write/read hazard on X7
    applyStimulus(1'b1, 1'b1, 5'd7, 64'h11, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd7, 64'h22, 5'd7, 5'd5);
`ifdef WB_REGFILE_BYPASS_EN
    exp_a = 64'h22;
`else
    exp_a = 64'h11;
`endif
    checkOutput("x7_hazard_a", rd_data_a, exp_a);
    checkOutput("x7_hazard_other_b", rd_data_b, 64'h0123_4567_89AB_CDEF);
    tick();
    applyStimulus(1'b1, 1'b0, 5'd0, 64'h0, 5'd7, 5'd7);
    checkOutput("x7_after_a", rd_data_a, 64'h22);
    checkOutput("x7_after_b", rd_data_b, 64'h22);

    // RegWrite low: no store and no forward
    applyStimulus(1'b1, 1'b1, 5'd9, 64'h99, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 5'd9, 64'hFF, 5'd9, 5'd9);
    checkOutput("x9_nowe_same_a", rd_data_a, 64'h99);
    tick();
    checkOutput("x9_nowe_next_a", rd_data_a, 64'h99);
    checkOutput("x9_nowe_next_b", rd_data_b, 64'h99);

    // Back-to-back burst X1..X30 = index
    for (int i = 1; i <= 30; i++) begin
      applyStimulus(1'b1, 1'b1, reg_addr_t'(i), word_t'(i), 5'd0, 5'd0);
      tick();
    end
    for (int i = 1; i <= 30; i++) begin
      applyStimulus(1'b1, 1'b0, 5'd0, 64'h0, reg_addr_t'(i), reg_addr_t'(31 - i));
      checkOutput($sformatf("burst_a_x%0d", i), rd_data_a, word_t'(i));
      checkOutput($sformatf("burst_b_x%0d", 31 - i), rd_data_b, word_t'(31 - i));
    end

    // Second burst interrupted by a one-cycle reset while targeting X15
    for (int i = 1; i <= 14; i++) begin
      applyStimulus(1'b1, 1'b1, reg_addr_t'(i), word_t'(i + 100), 5'd0, 5'd0);
      tick();
    end
    applyStimulus(1'b0, 1'b1, 5'd15, 64'd115, 5'd15, 5'd14);
    checkOutput("rst_nobypass_a_x15", rd_data_a, 64'd15);
    checkOutput("rst_cycle_b_x14", rd_data_b, 64'd114);
    tick();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 1'b0, 5'd0, 64'h0, reg_addr_t'(i), reg_addr_t'(31 - i));
      checkOutput($sformatf("midrst_a_x%0d", i), rd_data_a, 64'h0);
      checkOutput($sformatf("midrst_b_x%0d", 31 - i), rd_data_b, 64'h0);
    end

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule
